regfile_write_arbiter: RTL

//  Owns the register file's single write port (wtReg/wtData/regWrite) and shares it among

---
 rtl/regfile_write_arbiter_if.sv | 26 ++
 rtl/regfile_write_arbiter.sv | 106 ++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the requesters and the register-file write arbiter.
// Requesters drive the master side; the arbiter owns the slave side and the write port.
interface regfile_write_arbiter_if #(
  parameter int NREQ = 2,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*5-1:0]  req_reg;
  logic [NREQ*DW-1:0] req_data;
  logic [4:0]         wtReg;
  logic [DW-1:0]      wtData;
  logic               regWrite;
  logic               init_done;
  logic               zero_drop;

  modport master (
    output req_valid, req_reg, req_data,
    input  req_ready, wtReg, wtData, regWrite, init_done, zero_drop
  );

  modport slave (
    input  req_valid, req_reg, req_data,
    output req_ready, wtReg, wtData, regWrite, init_done, zero_drop
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin owner of the register file write port; zeroes every register after reset
// and discards writes aimed at $zero.
module regfile_write_arbiter #(
  parameter int NREQ       = 2,
  parameter int DW         = 32,
  parameter int NREGS      = 32,
  parameter int CLR_ON_RST = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_write_arbiter_if.slave bus
);
  localparam int            PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [4:0]    LAST_REG = 5'(NREGS - 1);
  localparam logic [PW-1:0] LAST_REQ = PW'(NREQ - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t          state, nextState;
  logic [4:0]      clrCnt;
  logic [PW-1:0]   rrPtr, winner, nextPtr;
  logic [PW:0]     cand;
  logic            found;
  logic [NREQ-1:0] grant;
  logic [4:0]      selReg;
  logic [DW-1:0]   selData;
  logic [4:0]      wrAddr;
  logic [DW-1:0]   wrData;
  logic            wrEn, doneFlag, dropFlag;

  always_ff @(posedge clk) begin
    if (rst) state <= (CLR_ON_RST != 0) ? INIT : RUN;
    else     state <= nextState;
  end

  // Search starts at rrPtr and wraps, so the last winner drops to lowest priority
  always_comb begin
    nextState = state;
    grant     = '0;
    winner    = '0;
    found     = 1'b0;
    cand      = '0;
    if (state == INIT) begin
      if (clrCnt == LAST_REG) nextState = RUN;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        cand = {1'b0, rrPtr} + (PW+1)'(k);
        if (cand > {1'b0, LAST_REQ}) cand = cand - (PW+1)'(NREQ);
        if (!found && bus.req_valid[cand[PW-1:0]]) begin
          found  = 1'b1;
          winner = cand[PW-1:0];
        end
      end
      if (found) grant[winner] = 1'b1;
    end
  end

  assign nextPtr = (winner == LAST_REQ) ? '0 : winner + 1'b1;

  always_comb begin
    selReg  = '0;
    selData = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (grant[j]) begin
        selReg  = bus.req_reg[5*j +: 5];
        selData = bus.req_data[DW*j +: DW];
      end
    end
  end

  // Writes to $zero still consume the grant and advance the pointer, but only pulse zero_drop
  always_ff @(posedge clk) begin
    if (rst) begin
      clrCnt   <= '0;
      rrPtr    <= '0;
      wrEn     <= 1'b0;
      wrAddr   <= '0;
      wrData   <= '0;
      dropFlag <= 1'b0;
      doneFlag <= (CLR_ON_RST == 0);
    end else if (state == INIT) begin
      wrEn     <= 1'b1;
      wrAddr   <= clrCnt;
      wrData   <= '0;
      dropFlag <= 1'b0;
      clrCnt   <= clrCnt + 1'b1;
      if (clrCnt == LAST_REG) doneFlag <= 1'b1;
    end else if (found) begin
      wrAddr   <= selReg;
      wrData   <= selData;
      rrPtr    <= nextPtr;
      wrEn     <= (selReg != 5'd0);
      dropFlag <= (selReg == 5'd0);
    end else begin
      wrEn     <= 1'b0;
      dropFlag <= 1'b0;
    end
  end

  assign bus.req_ready = grant;
  assign bus.wtReg     = wrAddr;
  assign bus.wtData    = wrData;
  assign bus.regWrite  = wrEn;
  assign bus.init_done = doneFlag;
  assign bus.zero_drop = dropFlag;
endmodule
